// File: rtl/ipf_pkg.sv
// Shared constants, state encoding and LCU raster-walk helpers for the IPF LCU feeder.
package ipf_pkg;

  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;

  localparam logic [1:0] LCU_16  = 2'd0;
  localparam logic [1:0] LCU_32  = 2'd1;
  localparam logic [1:0] LCU_64  = 2'd2;
  localparam logic [1:0] LCU_BAD = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} feeder_state_t;

  typedef struct packed {
    logic [2:0] ly;
    logic [2:0] lx;
    logic [5:0] r;
    logic [5:0] c;
  } lcu_pos_t;

  function automatic logic [5:0] lcu_last(input logic [1:0] size);
    case (size)
      LCU_16:  return 6'd15;
      LCU_32:  return 6'd31;
      LCU_64:  return 6'd63;
      default: return 6'd63;
    endcase
  endfunction

  function automatic logic [2:0] lcu_max(input logic [1:0] size);
    case (size)
      LCU_16:  return 3'd7;
      LCU_32:  return 3'd3;
      LCU_64:  return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic pos_is_last(input lcu_pos_t p, input logic [1:0] size);
    return (p.c == lcu_last(size)) && (p.r == lcu_last(size)) &&
           (p.lx == lcu_max(size)) && (p.ly == lcu_max(size));
  endfunction

  // Column fastest, then row, then LCU x, then LCU y; the final position wraps to zero.
  function automatic lcu_pos_t pos_next(input lcu_pos_t p, input logic [1:0] size);
    lcu_pos_t n;
    n = p;
    if (p.c != lcu_last(size)) begin
      n.c = p.c + 6'd1;
    end else begin
      n.c = '0;
      if (p.r != lcu_last(size)) begin
        n.r = p.r + 6'd1;
      end else begin
        n.r = '0;
        if (p.lx != lcu_max(size)) begin
          n.lx = p.lx + 3'd1;
        end else begin
          n.lx = '0;
          n.ly = (p.ly == lcu_max(size)) ? 3'd0 : p.ly + 3'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [ADDR_W-1:0] pos_addr(input lcu_pos_t p, input logic [1:0] size);
    logic [6:0] row;
    logic [6:0] col;
    row = (7'(p.ly) << (3'd4 + 3'(size))) + 7'(p.r);
    col = (7'(p.lx) << (3'd4 + 3'(size))) + 7'(p.c);
    return ADDR_W'(int'(row) * IMG_W + int'(col));
  endfunction

endpackage

// File: rtl/ipf_skid_fifo.sv
// Two-entry pixel FIFO; when empty, the incoming word is visible on head so it can
// be forwarded in the same cycle it arrives.
module ipf_skid_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       through;
  logic       pop_stored;

  assign full       = (count == 2'd2);
  assign empty      = (count == 2'd0);
  assign head       = empty ? wdata : mem[rd_ptr];
  assign through    = empty && push && pop;
  assign pop_stored = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (!through) begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= !wr_ptr;
      end
      if (pop_stored) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop_stored};
    end
  end

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Walks a 128x128 image LCU by LCU, reading pixels from image memory and streaming
// them to the in-loop filter with busy backpressure.
module ipf_lcu_feeder
  import ipf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_lcu_size,
  input  logic [1:0]        cfg_ipf_type,
  input  logic [4:0]        cfg_ipf_band_pos,
  input  logic              cfg_ipf_wo_class,
  input  logic [15:0]       cfg_ipf_offset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic [1:0]        ipf_type,
  output logic [4:0]        ipf_band_pos,
  output logic              ipf_wo_class,
  output logic [15:0]       ipf_offset,
  output logic              done,
  output logic              cfg_err
);

  feeder_state_t state, state_next;
  lcu_pos_t      rd_pos, out_pos;
  logic          rd_pending;
  logic          pop;
  logic          last_popped;
  logic          start_ok;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  assign start_ok = (state == ST_IDLE) && start && (cfg_lcu_size != LCU_BAD);
  // A read is only issued when the FIFO can absorb it even if busy holds from now on.
  assign mem_rd   = (state == ST_RUN) && !busy && !fifo_full && (fifo_empty || !rd_pending);
  assign mem_addr = pos_addr(rd_pos, lcu_size);
  assign pop      = !busy && (!fifo_empty || rd_pending);
  assign done     = (state == ST_DONE);

  ipf_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pending),
    .pop   (pop),
    .wdata (mem_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_RUN;
      ST_RUN:   if (mem_rd && pos_is_last(rd_pos, lcu_size)) state_next = ST_DRAIN;
      ST_DRAIN: if (last_popped && fifo_empty && !rd_pending) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_pending   <= 1'b0;
      rd_pos       <= '0;
      out_pos      <= '0;
      last_popped  <= 1'b0;
      in_en        <= 1'b0;
      din          <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
      lcu_size     <= '0;
      ipf_type     <= '0;
      ipf_band_pos <= '0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= '0;
      cfg_err      <= 1'b0;
    end else begin
      state      <= state_next;
      rd_pending <= mem_rd;
      in_en      <= pop;
      cfg_err    <= (state == ST_IDLE) && start && (cfg_lcu_size == LCU_BAD);
      if (mem_rd) rd_pos <= pos_next(rd_pos, lcu_size);
      // LCU coordinates move together with the first pixel of each new LCU.
      if (pop) begin
        din     <= fifo_head;
        out_pos <= pos_next(out_pos, lcu_size);
        if (out_pos.r == 6'd0 && out_pos.c == 6'd0) begin
          lcu_x <= out_pos.lx;
          lcu_y <= out_pos.ly;
        end
        if (pos_is_last(out_pos, lcu_size)) last_popped <= 1'b1;
      end
      if (start_ok) begin
        lcu_size     <= cfg_lcu_size;
        ipf_type     <= cfg_ipf_type;
        ipf_band_pos <= cfg_ipf_band_pos;
        ipf_wo_class <= cfg_ipf_wo_class;
        ipf_offset   <= cfg_ipf_offset;
        rd_pos       <= '0;
        out_pos      <= '0;
        last_popped  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: table of frame scenarios plus hand-written
// reset-replay and illegal-size sequences, with a per-pixel scoreboard.
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start;
  logic [1:0]  cfg_lcu_size, cfg_ipf_type;
  logic [4:0]  cfg_ipf_band_pos;
  logic        cfg_ipf_wo_class;
  logic [15:0] cfg_ipf_offset;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata = 8'hEE;
  logic        busy;
  logic        in_en;
  logic [7:0]  din;
  logic [2:0]  lcu_x, lcu_y;
  logic [1:0]  lcu_size, ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic        done, cfg_err;

  ipf_lcu_feeder dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_lcu_size     (cfg_lcu_size),
    .cfg_ipf_type     (cfg_ipf_type),
    .cfg_ipf_band_pos (cfg_ipf_band_pos),
    .cfg_ipf_wo_class (cfg_ipf_wo_class),
    .cfg_ipf_offset   (cfg_ipf_offset),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .busy             (busy),
    .in_en            (in_en),
    .din              (din),
    .lcu_x            (lcu_x),
    .lcu_y            (lcu_y),
    .lcu_size         (lcu_size),
    .ipf_type         (ipf_type),
    .ipf_band_pos     (ipf_band_pos),
    .ipf_wo_class     (ipf_wo_class),
    .ipf_offset       (ipf_offset),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic [1:0]  ipf_type;
    logic [4:0]  band;
    logic        wo;
    logic [15:0] offset;
    int          busy_mode;
    int          restart_at;
    int          reset_at;
    int          exp_pixels;
    int          exp_done;
    logic [2:0]  exp_lx;
    logic [2:0]  exp_ly;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pix_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cur_size = 0;
  int start_cyc = 0;
  int first_cyc = -1;
  bit prev_busy = 1'b0;
  bit prev_in_en = 1'b0;
  logic        pend_valid = 1'b0;
  logic [13:0] pend_addr = '0;

  function automatic logic [7:0] mem_val(input logic [13:0] a);
    return a[7:0];
  endfunction

  // Image memory: data for a read strobed in cycle t is presented during cycle t+1.
  always @(negedge clk) begin
    pend_valid <= mem_rd;
    pend_addr  <= mem_addr;
  end
  always @(posedge clk) mem_rdata <= pend_valid ? mem_val(pend_addr) : 8'hEE;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expected_pixel(input int k, input int size, output logic [13:0] a,
                                output logic [2:0] lx, output logic [2:0] ly);
    int n, per, lcu, w, r, c, nl;
    n   = 16 << size;
    per = n * n;
    lcu = k / per;
    w   = k % per;
    r   = w / n;
    c   = w % n;
    nl  = 128 / n;
    lx  = 3'(lcu % nl);
    ly  = 3'(lcu / nl);
    a   = 14'((int'(ly) * n + r) * 128 + int'(lx) * n + c);
  endtask

  // Scoreboard: every pixel, every read address, backpressure rules and done placement.
  always @(negedge clk) begin
    logic [13:0] ea;
    logic [2:0]  elx, ely;
    if (!reset) begin
      if (cfg_err) err_cnt++;
      if (prev_busy) check("in_en_after_busy", 32'(in_en), 32'd0);
      if (busy) check("rd_while_busy", 32'(mem_rd), 32'd0);
      if (in_en) begin
        if (pix_cnt == 0) first_cyc = cyc;
        expected_pixel(pix_cnt, cur_size, ea, elx, ely);
        check("din", 32'(din), 32'(mem_val(ea)));
        check("lcu_x", 32'(lcu_x), 32'(elx));
        check("lcu_y", 32'(lcu_y), 32'(ely));
        pix_cnt++;
      end
      if (mem_rd) begin
        expected_pixel(rd_cnt, cur_size, ea, elx, ely);
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("fifo_room", 32'((rd_cnt - pix_cnt) < 2), 32'd1);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", 32'({prev_in_en, pix_cnt == 16384}), 32'd3);
      end
    end
    prev_busy  = busy;
    prev_in_en = in_en;
  end

  task automatic check_reset_outputs();
    check("rst_in_en", 32'(in_en), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_lcu_x", 32'(lcu_x), 32'd0);
    check("rst_lcu_y", 32'(lcu_y), 32'd0);
    check("rst_lcu_size", 32'(lcu_size), 32'd0);
    check("rst_ipf_type", 32'(ipf_type), 32'd0);
    check("rst_band_pos", 32'(ipf_band_pos), 32'd0);
    check("rst_wo_class", 32'(ipf_wo_class), 32'd0);
    check("rst_offset", 32'(ipf_offset), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
  endtask

  task automatic start_frame(input logic [1:0] size, input logic [1:0] t, input logic [4:0] band,
                             input logic wo, input logic [15:0] off);
    @(posedge clk); #1;
    pix_cnt   = 0;
    rd_cnt    = 0;
    done_cnt  = 0;
    first_cyc = -1;
    cur_size  = int'(size);
    start     = 1'b1;
    cfg_lcu_size     = size;
    cfg_ipf_type     = t;
    cfg_ipf_band_pos = band;
    cfg_ipf_wo_class = wo;
    cfg_ipf_offset   = off;
    busy      = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic check_output(input vec_t v, input bit aborted);
    bit zeroed;
    zeroed = (v.reset_at >= 0);
    check("frame_end", 32'((done_cnt > 0) || aborted), 32'd1);
    check("pixels", 32'(pix_cnt), 32'(v.exp_pixels));
    check("done_count", 32'(done_cnt), 32'(v.exp_done));
    check("first_latency", 32'(first_cyc - start_cyc), 32'(v.exp_lat));
    check("final_lcu_x", 32'(lcu_x), 32'(v.exp_lx));
    check("final_lcu_y", 32'(lcu_y), 32'(v.exp_ly));
    check("hold_lcu_size", 32'(lcu_size), zeroed ? 32'd0 : 32'(v.size));
    check("hold_ipf_type", 32'(ipf_type), zeroed ? 32'd0 : 32'(v.ipf_type));
    check("hold_band_pos", 32'(ipf_band_pos), zeroed ? 32'd0 : 32'(v.band));
    check("hold_wo_class", 32'(ipf_wo_class), zeroed ? 32'd0 : 32'(v.wo));
    check("hold_offset", 32'(ipf_offset), zeroed ? 32'd0 : 32'(v.offset));
  endtask

  task automatic apply_stimulus(input vec_t v);
    int  stall_left;
    bit  stalled;
    bit  aborted;
    stall_left = 0;
    stalled    = 1'b0;
    aborted    = 1'b0;
    start_frame(v.size, v.ipf_type, v.band, v.wo, v.offset);
    for (int c = 1; c < 40000 && done_cnt == 0 && !aborted; c++) begin
      @(posedge clk); #1;
      start            = 1'b0;
      cfg_lcu_size     = 2'd3;
      cfg_ipf_type     = ~v.ipf_type;
      cfg_ipf_band_pos = ~v.band;
      cfg_ipf_wo_class = ~v.wo;
      cfg_ipf_offset   = ~v.offset;
      if (c == v.restart_at) begin
        start        = 1'b1;
        cfg_lcu_size = 2'd2;
      end
      case (v.busy_mode)
        1: busy = ((c / 3) % 2) == 1;
        2: begin
          if (!stalled && pix_cnt >= 100) begin
            stalled    = 1'b1;
            stall_left = 20;
          end
          busy = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        default: busy = 1'b0;
      endcase
      if (v.reset_at >= 0 && pix_cnt >= v.reset_at) begin
        reset = 1'b1;
        #1;
        check_reset_outputs();
        aborted = 1'b1;
      end
    end
    busy  = 1'b0;
    start = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    check_output(v, aborted);
  endtask

  initial begin
    start = 1'b0;
    busy  = 1'b0;
    cfg_lcu_size = '0; cfg_ipf_type = '0; cfg_ipf_band_pos = '0;
    cfg_ipf_wo_class = 1'b0; cfg_ipf_offset = '0;

    //           size  type  band   wo    offset    busy rst_at reset_at pix    done lx    ly    lat
    vecs[0] = '{2'd0, 2'd1, 5'd3,  1'b1, 16'h1234, 0,   2000,  -1,      16384, 1,   3'd7, 3'd7, 3};
    vecs[1] = '{2'd2, 2'd2, 5'd17, 1'b0, 16'hBEEF, 1,   -1,    -1,      16384, 1,   3'd1, 3'd1, 3};
    vecs[2] = '{2'd1, 2'd3, 5'd31, 1'b1, 16'h8001, 2,   -1,    -1,      16384, 1,   3'd3, 3'd3, 3};
    vecs[3] = '{2'd0, 2'd2, 5'd9,  1'b0, 16'h00FF, 0,   -1,    5000,    5000,  0,   3'd0, 3'd0, 3};

    #2 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_mem_rd", 32'(mem_rd), 32'd0);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] frame vector %0d: size=%0d busy_mode=%0d", i, vecs[i].size, vecs[i].busy_mode);
      apply_stimulus(vecs[i]);
    end

    // After an aborted frame a new start must replay the image from address 0.
    start_frame(2'd0, 2'd1, 5'd2, 1'b1, 16'h5A5A);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("replay_progress", 32'(pix_cnt >= 30), 32'd1);
    check("replay_latency", 32'(first_cyc - start_cyc), 32'd3);
    reset = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("replay_no_done", 32'(done_cnt), 32'd0);

    // Illegal LCU size: a single cfg_err pulse and no traffic.
    @(posedge clk); #1;
    err_cnt  = 0;
    rd_cnt   = 0;
    pix_cnt  = 0;
    done_cnt = 0;
    start            = 1'b1;
    cfg_lcu_size     = 2'd3;
    cfg_ipf_type     = 2'd3;
    cfg_ipf_band_pos = 5'd21;
    cfg_ipf_wo_class = 1'b1;
    cfg_ipf_offset   = 16'hCAFE;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    check("cfg_err_low", 32'(cfg_err), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("cfg_err_count", 32'(err_cnt), 32'd1);
    check("cfg_err_no_rd", 32'(rd_cnt), 32'd0);
    check("cfg_err_no_pix", 32'(pix_cnt), 32'd0);
    check("cfg_err_no_done", 32'(done_cnt), 32'd0);
    check("cfg_err_offset_kept", 32'(ipf_offset), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
